// File: rtl/wb_arbiter_queued_pkg.sv
// Shared types and default widths for the writeback arbiter slice.
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  // Pipeline result source; the reserved code decodes exactly like the ALU source.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO that buffers long-latency results ahead of the register-file port.
module wb_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_arbiter_queued.sv
// Writeback arbiter: merges the in-order pipeline result with queued long-latency results
// onto the single register-file write port. reset_i is asynchronous and active-low.
module wb_arbiter_queued
  import wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int RA_W         = RA_W_DEF,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1,
  localparam int SW    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pipe_valid_i,
  input  logic             pipe_we_i,
  input  logic [RA_W-1:0]  pipe_rd_i,
  input  logic [1:0]       pipe_sel_i,
  input  logic [XLEN-1:0]  pipe_alu_i,
  input  logic [XLEN-1:0]  pipe_mem_i,
  input  logic [XLEN-1:0]  pipe_link_i,
  input  logic             lat_valid_i,
  output logic             lat_ready_o,
  input  logic [RA_W-1:0]  lat_rd_i,
  input  logic [XLEN-1:0]  lat_data_i,
  output logic             rf_we_o,
  output logic [RA_W-1:0]  rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             wb_stall_o,
  output logic [CNT_W-1:0] lq_count_o
);

  logic             pipe_req, push, pop, lq_full, lq_empty;
  logic [RA_W-1:0]  head_rd;
  logic [XLEN-1:0]  head_data, pipe_result;

  logic             rf_we_q, rf_we_d;
  logic [RA_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             stall_q, stall_d;
  logic [SW-1:0]    starve_q, starve_d;

  assign pipe_req    = pipe_valid_i & pipe_we_i & (pipe_rd_i != '0);
  assign lat_ready_o = ~lq_full;
  assign push        = lat_valid_i & lat_ready_o;

  wb_sync_fifo #(
    .WIDTH(RA_W + XLEN),
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .wdata_i ({lat_rd_i, lat_data_i}),
    .pop_i   (pop),
    .rdata_o ({head_rd, head_data}),
    .count_o (lq_count_o),
    .full_o  (lq_full),
    .empty_o (lq_empty)
  );

  always_comb begin
    case (wb_sel_e'(pipe_sel_i))
      WB_MEM:  pipe_result = pipe_mem_i;
      WB_LINK: pipe_result = pipe_link_i;
      default: pipe_result = pipe_alu_i;
    endcase
  end

  // A pipe request always wins; a well-behaved upstream keeps the slot empty
  // while wb_stall is high, which hands the port to the queue head.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    starve_d   = '0;
    stall_d    = 1'b0;
    pop        = 1'b0;
    if (pipe_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd_i;
      rf_wdata_d = pipe_result;
      if (!lq_empty) starve_d = starve_q + 1'b1;
    end else if (!lq_empty) begin
      pop        = 1'b1;
      rf_we_d    = (head_rd != '0);
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
    if (starve_d == SW'(STARVE_LIMIT)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
      starve_q   <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      starve_q   <= starve_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign wb_stall_o = stall_q;

  pipeDuringStall: assert property (@(posedge clk_i) disable iff (!reset_i)
    wb_stall_o |-> !pipe_valid_i);

endmodule
